fetch_sequencer: RTL and testbench



---
 rtl/picomips_pkg.sv | 20 ++
 rtl/sync2.sv | 23 ++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: default widths, control opcodes and the fetch sequencer states.
package picomips_pkg;

    localparam int P_SIZE  = 6;
    localparam int I_SIZE  = 12;
    localparam int OP_SIZE = 4;

    localparam logic [3:0] OP_WAIT = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        WAIT_HI,
        WAIT_LO,
        STEP,
        HALTED
    } seq_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous board inputs; both stages clear to 0 on reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer driving the PC increment, with WAIT (go press-and-release) and HALT.
// Optional single-step build: define FETCH_SINGLE_STEP_EN to add the stepMode input.
module fetch_sequencer #(
    parameter int P_SIZE  = picomips_pkg::P_SIZE,
    parameter int I_SIZE  = picomips_pkg::I_SIZE,
    parameter int OP_SIZE = picomips_pkg::OP_SIZE
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [I_SIZE-1:0] instrIn,
    input  logic [P_SIZE-1:0] pcAddr,
    input  logic              go,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              stepMode,
`endif
    output logic              inc,
    output logic [I_SIZE-1:0] irOut,
    output logic              execEn,
    output logic              waiting,
    output logic              halted
);

    import picomips_pkg::*;

    seq_state_t        state;
    seq_state_t        nextState;
    logic              goS;
    logic              stepHold;
    logic [OP_SIZE-1:0] opcode;
    logic              isWait;
    logic              isHalt;
    logic              unusedPcAddr;

    // pcAddr is carried for debug visibility only
    assign unusedPcAddr = ^pcAddr;

    sync2 #(.WIDTH(1)) goSync (
        .clk  (clk),
        .nRst (nRst),
        .d    (go),
        .q    (goS)
    );

`ifdef FETCH_SINGLE_STEP_EN
    assign stepHold = stepMode;
`else
    assign stepHold = 1'b0;
`endif

    assign opcode = irOut[I_SIZE-1 -: OP_SIZE];
    assign isWait = (opcode == OP_SIZE'(OP_WAIT));
    assign isHalt = (opcode == OP_SIZE'(OP_HALT));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // The instruction register only loads in FETCH, so decode always sees a stable word
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            irOut <= '0;
        end else if (state == FETCH) begin
            irOut <= instrIn;
        end
    end

    always_comb begin
        nextState = state;
        inc       = 1'b0;
        execEn    = 1'b0;
        waiting   = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                nextState = EXEC;
            end
            EXEC: begin
                if (isHalt) begin
                    nextState = HALTED;
                end else if (isWait) begin
                    nextState = WAIT_HI;
                end else begin
                    execEn = 1'b1;
                    if (stepHold) begin
                        nextState = WAIT_HI;
                    end else begin
                        inc       = 1'b1;
                        nextState = FETCH;
                    end
                end
            end
            WAIT_HI: begin
                waiting = 1'b1;
                if (goS) begin
                    nextState = WAIT_LO;
                end
            end
            // One release per WAIT: advance only once the held button drops
            WAIT_LO: begin
                waiting = 1'b1;
                if (!goS) begin
                    nextState = STEP;
                end
            end
            STEP: begin
                inc       = 1'b1;
                nextState = FETCH;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, hand-written WAIT/HALT/reset sequences,
// and a randomized run against an instruction-level reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        go = 1'b0;
    logic [11:0] instrIn;
    logic [5:0]  pc;
    logic        inc;
    logic        execEn;
    logic        waiting;
    logic        halted;
    logic [11:0] irOut;
`ifdef FETCH_SINGLE_STEP_EN
    logic        stepMode = 1'b0;
`endif

    logic [11:0] mem [64];
    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    // Bench-side program counter, advanced by the sequencer's inc request
    always @(posedge clk or negedge nRst) begin
        if (!nRst) pc <= 6'd0;
        else if (inc) pc <= pc + 6'd1;
    end

    assign instrIn = mem[pc];

    fetch_sequencer dut (
        .clk     (clk),
        .nRst    (nRst),
        .instrIn (instrIn),
        .pcAddr  (pc),
        .go      (go),
`ifdef FETCH_SINGLE_STEP_EN
        .stepMode(stepMode),
`endif
        .inc     (inc),
        .irOut   (irOut),
        .execEn  (execEn),
        .waiting (waiting),
        .halted  (halted)
    );

    typedef struct {
        logic [11:0] instr;
        logic        expExec;
        logic        expIncExec;
        logic        expWaiting;
        logic        expHalted;
    } vec_t;

    vec_t vecs[7];

    // Reference model: where the current instruction is in its life (0 fetch, 1 execute,
    // 2 waiting on the button, 3 advancing), plus the go history seen through two flops
    int          slot;
    bit          mPressed;
    bit          mHalted;
    logic [5:0]  mPc;
    logic [11:0] mIr;
    bit          g1;
    bit          gS;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic eInc, input logic eExec,
                            input logic eWait, input logic eHalt, input logic [11:0] eIr);
        checkOutput({tag, ".inc"},     32'(inc),     32'(eInc));
        checkOutput({tag, ".execEn"},  32'(execEn),  32'(eExec));
        checkOutput({tag, ".waiting"}, 32'(waiting), 32'(eWait));
        checkOutput({tag, ".halted"},  32'(halted),  32'(eHalt));
        checkOutput({tag, ".irOut"},   32'(irOut),   32'(eIr));
    endtask

    task automatic applyStimulus(input logic [11:0] word);
        for (int i = 0; i < 64; i++) mem[i] = word;
    endtask

    task automatic resetDut();
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic modelReset();
        slot = 0; mPressed = 0; mHalted = 0;
        mPc = 6'd0; mIr = 12'd0; g1 = 0; gS = 0;
    endtask

    function automatic bit isNormal(input logic [11:0] w);
        return (w[11:8] != 4'hE) && (w[11:8] != 4'hF);
    endfunction

    function automatic bit stepNow();
`ifdef FETCH_SINGLE_STEP_EN
        return stepMode;
`else
        return 1'b0;
`endif
    endfunction

    // Called right after a rising edge; go/stepMode still hold their pre-edge values
    task automatic modelAdvance();
        if (!mHalted) begin
            case (slot)
                0: begin mIr = mem[mPc]; slot = 1; end
                1: begin
                    if (mIr[11:8] == 4'hF) mHalted = 1;
                    else if (mIr[11:8] == 4'hE || stepNow()) begin slot = 2; mPressed = 0; end
                    else begin mPc = mPc + 6'd1; slot = 0; end
                end
                2: begin
                    if (!mPressed) begin if (gS) mPressed = 1; end
                    else if (!gS) slot = 3;
                end
                default: begin mPc = mPc + 6'd1; slot = 0; end
            endcase
        end
        gS = g1;
        g1 = go;
    endtask

    task automatic countIncAfterRelease(input string tag, input int window);
        int firstAt;
        int incCount;
        firstAt = 0;
        incCount = 0;
        go = 1'b0;
        for (int i = 1; i <= window; i++) begin
            @(negedge clk);
            if (inc) begin
                if (firstAt == 0) firstAt = i;
                incCount++;
            end
        end
        checkOutput({tag, ".incDelay"}, 32'(firstAt), 32'd3);
        checkOutput({tag, ".incCount"}, 32'(incCount), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int incSeen;
        int bad;
        bit prevInc;
        int haltRun;
        logic [3:0] op;

        vecs[0] = '{12'h123, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{12'hDFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{12'hE00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{12'hEFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{12'hF00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{12'hFAB, 1'b0, 1'b0, 1'b0, 1'b1};

        // Table: fetch, execute, and the cycle after execute for each opcode class
        for (int v = 0; v < 7; v++) begin
            go = 1'b0;
            applyStimulus(vecs[v].instr);
            resetDut();
            checkAll("tbl.reset", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            @(negedge clk);
            checkAll("tbl.exec", vecs[v].expIncExec, vecs[v].expExec, 1'b0, 1'b0, vecs[v].instr);
            @(negedge clk);
            checkAll("tbl.after", 1'b0, 1'b0, vecs[v].expWaiting, vecs[v].expHalted, vecs[v].instr);
            @(negedge clk);
            checkOutput("tbl.repeatInc", 32'(inc), 32'(vecs[v].expIncExec));
        end

        // WAIT with go idle for 50 cycles, then a 5-cycle press and release
        go = 1'b0;
        applyStimulus(12'hE00);
        resetDut();
        repeat (2) @(negedge clk);
        incSeen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (inc || !waiting) incSeen++;
        end
        checkOutput("wait.idle", 32'(incSeen), 32'd0);
        go = 1'b1;
        incSeen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (inc) incSeen++;
        end
        checkOutput("wait.pressNoInc", 32'(incSeen), 32'd0);
        countIncAfterRelease("wait", 10);
        checkOutput("wait.rewait", 32'(waiting), 32'd1);
        checkOutput("wait.pc", 32'(pc), 32'd1);

        // go already held before the WAIT is reached
        go = 1'b1;
        applyStimulus(12'hE00);
        resetDut();
        incSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inc) incSeen++;
        end
        checkOutput("held.noInc", 32'(incSeen), 32'd0);
        checkOutput("held.waiting", 32'(waiting), 32'd1);
        countIncAfterRelease("held", 10);

        // HALT absorbs everything except reset
        go = 1'b0;
        applyStimulus(12'hF00);
        resetDut();
        repeat (2) @(negedge clk);
        checkOutput("halt.entry", 32'(halted), 32'd1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            go = 1'($urandom_range(0, 1));
            if (inc || execEn || !halted) bad++;
        end
        checkOutput("halt.stuck", 32'(bad), 32'd0);
        @(posedge clk);
        #2 nRst = 1'b0;
        #1 checkAll("halt.reset", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        nRst = 1'b1;
        go = 1'b0;

        // Asynchronous reset while holding in WAIT_LO
        applyStimulus(12'hE00);
        resetDut();
        repeat (3) @(negedge clk);
        go = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("waitlo.waiting", 32'(waiting), 32'd1);
        @(posedge clk);
        #3 nRst = 1'b0;
        #1 checkAll("waitlo.reset", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("waitlo.pc", 32'(pc), 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        go = 1'b0;
        @(negedge clk);
        checkAll("waitlo.refetch", 1'b0, 1'b0, 1'b0, 1'b0, 12'hE00);

`ifdef FETCH_SINGLE_STEP_EN
        // Single-step: execute without advancing until a press-and-release
        stepMode = 1'b1;
        applyStimulus(12'h123);
        resetDut();
        @(negedge clk);
        checkAll("step.exec", 1'b0, 1'b1, 1'b0, 1'b0, 12'h123);
        incSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inc) incSeen++;
        end
        checkOutput("step.hold", 32'(incSeen), 32'd0);
        checkOutput("step.waiting", 32'(waiting), 32'd1);
        go = 1'b1;
        repeat (4) @(negedge clk);
        countIncAfterRelease("step", 6);
        checkOutput("step.pc", 32'(pc), 32'd1);
        stepMode = 1'b0;
`endif

        // Randomized program run against the reference model
        for (int i = 0; i < 64; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 80) op = 4'($urandom_range(0, 13));
            else if (r < 97) op = 4'hE;
            else op = 4'hF;
            mem[i] = {op, 8'($urandom)};
        end
        go = 1'b0;
        resetDut();
        modelReset();
        prevInc = 1'b0;
        haltRun = 0;
        for (int cyc = 0; cyc < 3000 && failCount < 20; cyc++) begin
            bit eExec;
            bit eInc;
            @(posedge clk);
            modelAdvance();
            @(negedge clk);
            eExec = !mHalted && slot == 1 && isNormal(mIr);
            eInc  = (eExec && !stepNow()) || (!mHalted && slot == 3);
            checkAll("rand", eInc, eExec, !mHalted && slot == 2, mHalted, mIr);
            checkOutput("rand.incPair", 32'(prevInc && inc), 32'd0);
            prevInc = inc;
            haltRun = mHalted ? haltRun + 1 : 0;
            if (haltRun >= 4 || $urandom_range(0, 499) == 0) begin
                nRst = 1'b0;
                modelReset();
                prevInc = 1'b0;
                haltRun = 0;
                @(negedge clk);
                nRst = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) go = ~go;
`ifdef FETCH_SINGLE_STEP_EN
            stepMode = ($urandom_range(0, 7) == 0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
